// File: rtl/sweep_sequencer.sv
// rtl/sweep_sequencer.sv - linear frequency-sweep sequencer for an NCO control word
//
// Steps ctrl_out from cfg_start toward cfg_stop by cfg_step, holding each word
// for cfg_dwell+2 cycles. Modes: 0/3 single sweep, 1 repeating sawtooth, 2 triangle.
//
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   start, stop          one-cycle sweep request / abort request
//   pause                (only with SWEEP_SEQ_PAUSE_EN) freezes dwell counting in RUN
//   cfg_start, cfg_stop  sweep endpoint words, latched on start
//   cfg_step, cfg_dwell  step magnitude (0 coerced to 1) and extra hold cycles
//   cfg_mode             sweep mode
//   ctrl_out             registered control word to the NCO
//   busy, done, wrap     sweep running, single-sweep completion pulse, reload/reversal pulse
//
// Optional feature macro: SWEEP_SEQ_PAUSE_EN

module sweep_sequencer #(
    parameter int CTRL_W  = 32,
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
`ifdef SWEEP_SEQ_PAUSE_EN
    input  logic               pause,
`endif
    input  logic [CTRL_W-1:0]  cfg_start,
    input  logic [CTRL_W-1:0]  cfg_stop,
    input  logic [CTRL_W-1:0]  cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    output logic [CTRL_W-1:0]  ctrl_out,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t              state;
    logic [CTRL_W-1:0]   sh_start;
    logic [CTRL_W-1:0]   sh_stop;
    logic [CTRL_W-1:0]   sh_step;
    logic [DWELL_W-1:0]  sh_dwell;
    logic [1:0]          sh_mode;
    logic [DWELL_W-1:0]  dwell_cnt;
    logic                dir_up;
    logic                to_stop;   // 1 on the outbound leg, 0 on the triangle return leg
    logic                hold;
    logic [CTRL_W-1:0]   target;

`ifdef SWEEP_SEQ_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign target = to_stop ? sh_stop : sh_start;

    // One step from cur toward tgt, clamped to tgt. The extra bit keeps the
    // sum/difference from wrapping past either end of the word range.
    function automatic logic [CTRL_W-1:0] step_toward(
        input logic [CTRL_W-1:0] cur,
        input logic [CTRL_W-1:0] tgt,
        input logic [CTRL_W-1:0] stp,
        input logic              up
    );
        logic [CTRL_W:0] sum;
        logic [CTRL_W:0] diff;
        logic [CTRL_W-1:0] res;
        sum  = {1'b0, cur} + {1'b0, stp};
        diff = {1'b0, cur} - {1'b0, stp};
        if (up) begin
            res = (sum > {1'b0, tgt}) ? tgt : sum[CTRL_W-1:0];
        end else begin
            res = (diff[CTRL_W] || (diff[CTRL_W-1:0] < tgt)) ? tgt : diff[CTRL_W-1:0];
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            ctrl_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            dwell_cnt <= '0;
            dir_up    <= 1'b1;
            to_stop   <= 1'b1;
            sh_start  <= '0;
            sh_stop   <= '0;
            sh_step   <= '0;
            sh_dwell  <= '0;
            sh_mode   <= '0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        sh_start  <= cfg_start;
                        sh_stop   <= cfg_stop;
                        sh_step   <= (cfg_step == '0) ? CTRL_W'(1) : cfg_step;
                        sh_dwell  <= cfg_dwell;
                        sh_mode   <= cfg_mode;
                        dir_up    <= (cfg_stop >= cfg_start);
                        to_stop   <= 1'b1;
                        ctrl_out  <= cfg_start;
                        dwell_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        busy      <= 1'b0;
                        dwell_cnt <= '0;
                        state     <= S_IDLE;
                    end else if (!hold) begin
                        if (dwell_cnt == sh_dwell) begin
                            state <= S_STEP;
                        end else begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    dwell_cnt <= '0;
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (ctrl_out != target) begin
                        ctrl_out <= step_toward(ctrl_out, target, sh_step, dir_up);
                        state    <= S_RUN;
                    end else begin
                        case (sh_mode)
                            2'd1: begin
                                ctrl_out <= sh_start;
                                wrap     <= 1'b1;
                                state    <= S_RUN;
                            end
                            2'd2: begin
                                // Reverse and take the first step of the new leg at
                                // once so the endpoint word is not held twice.
                                dir_up   <= ~dir_up;
                                to_stop  <= ~to_stop;
                                ctrl_out <= step_toward(ctrl_out, to_stop ? sh_start : sh_stop,
                                                        sh_step, ~dir_up);
                                wrap     <= 1'b1;
                                state    <= S_RUN;
                            end
                            default: begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_sequencer.sv
// tb/tb_sweep_sequencer.sv - directed self-checking bench for sweep_sequencer

module tb_sweep_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
`ifdef SWEEP_SEQ_PAUSE_EN
    logic        pause;
`endif
    logic [31:0] cfg_start;
    logic [31:0] cfg_stop;
    logic [31:0] cfg_step;
    logic [23:0] cfg_dwell;
    logic [1:0]  cfg_mode;
    logic [31:0] ctrl_out;
    logic        busy;
    logic        done;
    logic        wrap;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sweep_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
`ifdef SWEEP_SEQ_PAUSE_EN
        .pause     (pause),
`endif
        .cfg_start (cfg_start),
        .cfg_stop  (cfg_stop),
        .cfg_step  (cfg_step),
        .cfg_dwell (cfg_dwell),
        .cfg_mode  (cfg_mode),
        .ctrl_out  (ctrl_out),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Checks that word w is present for n consecutive observations while busy,
    // with wrap equal to first_wrap on the first one only; ticks after each.
    task automatic expect_word(input logic [31:0] w, input int n, input logic first_wrap);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("word_%0h_%0d", w, i), ctrl_out, w);
            chk($sformatf("busy_%0h_%0d", w, i), {31'b0, busy}, 32'd1);
            chk($sformatf("done_%0h_%0d", w, i), {31'b0, done}, 32'd0);
            chk($sformatf("wrap_%0h_%0d", w, i), {31'b0, wrap},
                {31'b0, (i == 0) ? first_wrap : 1'b0});
            tick();
        end
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                          input logic [23:0] dw, input logic [1:0] m);
        cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = dw; cfg_mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_start = 32'hDEAD_BEEF; cfg_stop = 32'h0; cfg_step = 32'h7; cfg_dwell = 24'd9; cfg_mode = 2'd1;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef SWEEP_SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0; cfg_mode = '0;
        tick(); tick();
        chk("rst_ctrl", ctrl_out, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_wrap", {31'b0, wrap}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Single upward sweep, dwell 3 -> 5 cycles per word
        launch(32'h1F751, 32'h1F951, 32'h100, 24'd3, 2'd0);
        expect_word(32'h1F751, 5, 1'b0);
        expect_word(32'h1F851, 5, 1'b0);
        expect_word(32'h1F951, 5, 1'b0);
        chk("m0up_done", {31'b0, done}, 32'd1);
        chk("m0up_busy", {31'b0, busy}, 32'd0);
        chk("m0up_ctrl", ctrl_out, 32'h1F951);
        tick();
        chk("m0up_done_end", {31'b0, done}, 32'd0);
        chk("m0up_ctrl_hold", ctrl_out, 32'h1F951);

        // Single downward sweep with clamped final step
        launch(32'h1000, 32'h0F00, 32'h60, 24'd0, 2'd3);
        expect_word(32'h1000, 2, 1'b0);
        expect_word(32'h0FA0, 2, 1'b0);
        expect_word(32'h0F40, 2, 1'b0);
        expect_word(32'h0F00, 2, 1'b0);
        chk("m0dn_done", {31'b0, done}, 32'd1);
        chk("m0dn_busy", {31'b0, busy}, 32'd0);
        chk("m0dn_ctrl", ctrl_out, 32'h0F00);
        tick();

        // Triangle
        launch(32'h10, 32'h30, 32'h10, 24'd0, 2'd2);
        expect_word(32'h10, 2, 1'b0);
        expect_word(32'h20, 2, 1'b0);
        expect_word(32'h30, 2, 1'b0);
        expect_word(32'h20, 2, 1'b1);
        expect_word(32'h10, 2, 1'b0);
        expect_word(32'h20, 2, 1'b1);
        expect_word(32'h30, 2, 1'b0);
        expect_word(32'h20, 1, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("tri_stop_busy", {31'b0, busy}, 32'd0);
        chk("tri_stop_ctrl", ctrl_out, 32'h20);
        tick();

        // Saw with abort mid-dwell
        launch(32'h100, 32'h300, 32'h100, 24'd2, 2'd1);
        expect_word(32'h100, 4, 1'b0);
        expect_word(32'h200, 4, 1'b0);
        expect_word(32'h300, 4, 1'b0);
        expect_word(32'h100, 4, 1'b1);
        expect_word(32'h200, 2, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("saw_stop_busy", {31'b0, busy}, 32'd0);
        chk("saw_stop_ctrl", ctrl_out, 32'h200);
        chk("saw_stop_done", {31'b0, done}, 32'd0);
        chk("saw_stop_wrap", {31'b0, wrap}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("saw_idle_busy", {31'b0, busy}, 32'd0);
            chk("saw_idle_ctrl", ctrl_out, 32'h200);
            chk("saw_idle_flags", {30'b0, done, wrap}, 32'd0);
        end

        // start and stop together in IDLE: stays idle
        cfg_start = 32'h555; cfg_stop = 32'h999; cfg_step = 32'h1; cfg_mode = 2'd0;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("both_busy", {31'b0, busy}, 32'd0);
        chk("both_ctrl", ctrl_out, 32'h200);
        tick();
        chk("both_busy2", {31'b0, busy}, 32'd0);

        // Zero step coerced to 1, then reset mid-sweep with start high
        launch(32'h40, 32'h42, 32'h0, 24'd0, 2'd0);
        expect_word(32'h40, 2, 1'b0);
        expect_word(32'h41, 2, 1'b0);
        expect_word(32'h42, 1, 1'b0);
        reset_n = 1'b0; start = 1'b1;
        tick();
        chk("midrst_ctrl", ctrl_out, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_flags", {30'b0, done, wrap}, 32'd0);
        reset_n = 1'b1; start = 1'b0;
        tick();
        chk("postrst_busy", {31'b0, busy}, 32'd0);
        chk("postrst_ctrl", ctrl_out, 32'h0);

        // Start/stop equal in triangle: wrap every dwell+2 cycles on a constant word
        launch(32'h77, 32'h77, 32'h5, 24'd1, 2'd2);
        expect_word(32'h77, 3, 1'b0);
        expect_word(32'h77, 3, 1'b1);
        expect_word(32'h77, 1, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("eq_stop_busy", {31'b0, busy}, 32'd0);

`ifdef SWEEP_SEQ_PAUSE_EN
        // Pause for 10 cycles mid-dwell extends the hold by exactly 10
        launch(32'h0, 32'h10, 32'h10, 24'd3, 2'd0);
        expect_word(32'h0, 2, 1'b0);
        pause = 1'b1;
        expect_word(32'h0, 10, 1'b0);
        pause = 1'b0;
        expect_word(32'h0, 3, 1'b0);
        chk("pause_next", ctrl_out, 32'h10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
